// File: rtl/debug_loader.sv
// UART debug/load controller in front of the mips core: program load, run, step, break.
// Optional DEBUG_LOADER_CHECKSUM_EN replaces the load ACK with an XOR of the payload.
module debug_loader #(
    parameter int SIZE        = 32,
    parameter int IMEM_ADDR_W = 10,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             i_rx_data,
    input  logic                   i_rx_valid,
    input  logic                   i_tx_busy,
    input  logic                   i_halt,
    output logic [7:0]             o_tx_data,
    output logic                   o_tx_valid,
    output logic                   o_stall,
    output logic                   o_cpu_rst,
    output logic                   o_imem_we,
    output logic [IMEM_ADDR_W-1:0] o_imem_addr,
    output logic [SIZE-1:0]        o_imem_data,
    output logic [2:0]             o_state
);

    localparam int NB = SIZE / 8;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN0 = 3'd1,
        LEN1 = 3'd2,
        DATA = 3'd3,
        RUN  = 3'd4,
        STEP = 3'd5,
        SEND = 3'd6
    } state_e;

    state_e                 state_q, state_d;
    logic                   stall_q, stall_d;
    logic                   cpu_rst_q, cpu_rst_d;
    logic                   we_q, we_d;
    logic [IMEM_ADDR_W-1:0] addr_q, addr_d;
    logic [SIZE-1:0]        data_q, data_d;
    logic [BW-1:0]          bcnt_q, bcnt_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [7:0]             len_lo_q, len_lo_d;
    logic                   step_q, step_d;
    logic [7:0]             reply_q, reply_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   tx_valid_q, tx_valid_d;
    logic [7:0]             load_reply;
    logic [CNT_W-1:0]       len_w;
    logic [SIZE+7:0]        shift_w;
    logic                   last_wr;

`ifdef DEBUG_LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;
    assign load_reply = csum_q;
`else
    assign load_reply = 8'h06;
`endif

    assign len_w   = CNT_W'({i_rx_data, len_lo_q});
    assign shift_w = {i_rx_data, data_q};
    assign last_wr = we_q && (cnt_q == CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            stall_q    <= 1'b1;
            cpu_rst_q  <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            bcnt_q     <= '0;
            cnt_q      <= '0;
            len_lo_q   <= '0;
            step_q     <= 1'b0;
            reply_q    <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
`ifdef DEBUG_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            stall_q    <= stall_d;
            cpu_rst_q  <= cpu_rst_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            bcnt_q     <= bcnt_d;
            cnt_q      <= cnt_d;
            len_lo_q   <= len_lo_d;
            step_q     <= step_d;
            reply_q    <= reply_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
`ifdef DEBUG_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        stall_d    = stall_q;
        cpu_rst_d  = cpu_rst_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        bcnt_d     = bcnt_q;
        cnt_d      = cnt_q;
        len_lo_d   = len_lo_q;
        step_d     = step_q;
        reply_d    = reply_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = 1'b0;
`ifdef DEBUG_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (i_rx_valid) begin
                    case (i_rx_data)
                        8'h4C: begin
                            state_d   = LEN0;
                            cpu_rst_d = 1'b1;
`ifdef DEBUG_LOADER_CHECKSUM_EN
                            csum_d    = '0;
`endif
                        end
                        8'h52: state_d = RUN;
                        8'h53: begin
                            state_d = STEP;
                            step_d  = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            LEN0: begin
                if (i_rx_valid) begin
                    len_lo_d = i_rx_data;
                    state_d  = LEN1;
                end
            end
            LEN1: begin
                if (i_rx_valid) begin
                    cnt_d = len_w;
                    if (len_w == '0) begin
                        state_d   = SEND;
                        cpu_rst_d = 1'b0;
                        reply_d   = load_reply;
                    end else begin
                        state_d = DATA;
                        addr_d  = '0;
                        bcnt_d  = '0;
                    end
                end
            end
            DATA: begin
                // Write strobe cycle: advance address and retire one word.
                if (we_q) begin
                    addr_d = addr_q + IMEM_ADDR_W'(1);
                    cnt_d  = cnt_q - CNT_W'(1);
                end
                if (last_wr) begin
                    cpu_rst_d = 1'b0;
                    state_d   = SEND;
                    reply_d   = load_reply;
                end else if (i_rx_valid) begin
                    data_d = shift_w[SIZE+7:8];
`ifdef DEBUG_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ i_rx_data;
`endif
                    if (bcnt_q == BW'(NB - 1)) begin
                        bcnt_d = '0;
                        we_d   = 1'b1;
                    end else begin
                        bcnt_d = bcnt_q + BW'(1);
                    end
                end
            end
            RUN: begin
                if (i_halt || (i_rx_valid && i_rx_data == 8'h42)) begin
                    stall_d = 1'b1;
                    state_d = SEND;
                    reply_d = 8'h48;
                end else begin
                    stall_d = 1'b0;
                end
            end
            STEP: begin
                if (step_q) begin
                    stall_d = 1'b1;
                    state_d = SEND;
                    reply_d = 8'h2E;
                end else if (i_halt) begin
                    state_d = SEND;
                    reply_d = 8'h48;
                end else begin
                    stall_d = 1'b0;
                    step_d  = 1'b1;
                end
            end
            SEND: begin
                if (!i_tx_busy) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = reply_q;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_tx_data   = tx_data_q;
    assign o_tx_valid  = tx_valid_q;
    assign o_stall     = stall_q;
    assign o_cpu_rst   = cpu_rst_q;
    assign o_imem_we   = we_q;
    assign o_imem_addr = addr_q;
    assign o_imem_data = data_q;
    assign o_state     = state_q;

endmodule

// File: tb/tb_debug_loader.sv
// Directed bench for debug_loader: reset, load, zero load, step, run/halt/break, wrap.
module tb_debug_loader;

`ifdef DEBUG_LOADER_CHECKSUM_EN
    localparam logic [7:0] LOAD_REPLY = 8'h44;
    localparam logic [7:0] ZERO_REPLY = 8'h00;
    localparam logic [7:0] WRAP_REPLY = 8'h00;
    localparam logic [7:0] RLD_REPLY  = 8'h30;
`else
    localparam logic [7:0] LOAD_REPLY = 8'h06;
    localparam logic [7:0] ZERO_REPLY = 8'h06;
    localparam logic [7:0] WRAP_REPLY = 8'h06;
    localparam logic [7:0] RLD_REPLY  = 8'h06;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        tx_busy = 1'b0;
    logic        halt = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        stall;
    logic        cpu_rst;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [2:0]  state;

    int n_cmp = 0;
    int n_err = 0;

    int          wr_n = 0;
    logic [1:0]  wr_addr [16];
    logic [31:0] wr_data [16];
    logic        wr_rst  [16];
    int          tx_cnt = 0;
    logic [7:0]  tx_last = '0;
    int          stall_lo = 0;

    debug_loader #(.SIZE(32), .IMEM_ADDR_W(2), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_rx_data   (rx_data),
        .i_rx_valid  (rx_valid),
        .i_tx_busy   (tx_busy),
        .i_halt      (halt),
        .o_tx_data   (tx_data),
        .o_tx_valid  (tx_valid),
        .o_stall     (stall),
        .o_cpu_rst   (cpu_rst),
        .o_imem_we   (we),
        .o_imem_addr (addr),
        .o_imem_data (wdata),
        .o_state     (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (we) begin
            if (wr_n < 16) begin
                wr_addr[wr_n] = addr;
                wr_data[wr_n] = wdata;
                wr_rst[wr_n]  = cpu_rst;
            end
            wr_n = wr_n + 1;
        end
        if (tx_valid) begin
            tx_cnt  = tx_cnt + 1;
            tx_last = tx_data;
        end
        if (!stall) stall_lo = stall_lo + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_tx(input string tag, input int start, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (tx_cnt != start) break;
            @(negedge clk);
        end
        chk(tag, 32'(tx_cnt - start), 32'd1);
    endtask

    task automatic clear_logs();
        wr_n     = 0;
        tx_cnt   = 0;
        stall_lo = 0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd1);
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Full load, all bytes back-to-back
        clear_logs();
        send(8'h4C);
        chk("load_cpu_rst", 32'(cpu_rst), 32'd1);
        send(8'h02); send(8'h00);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
        wait_tx("load_tx", 0, 40);
        chk("load_nwr", 32'(wr_n), 32'd2);
        chk("load_a0", 32'(wr_addr[0]), 32'd0);
        chk("load_d0", wr_data[0], 32'h44332211);
        chk("load_a1", 32'(wr_addr[1]), 32'd1);
        chk("load_d1", wr_data[1], 32'hDDCCBBAA);
        chk("load_rst_w0", 32'(wr_rst[0]), 32'd1);
        chk("load_rst_w1", 32'(wr_rst[1]), 32'd1);
        chk("load_reply", 32'(tx_last), 32'(LOAD_REPLY));
        chk("load_cpu_rst_end", 32'(cpu_rst), 32'd0);
        chk("load_stall", 32'(stall_lo), 32'd0);

        // Zero-length load
        repeat (2) @(negedge clk);
        clear_logs();
        send(8'h4C); send(8'h00); send(8'h00);
        wait_tx("zero_tx", 0, 20);
        repeat (10) @(negedge clk);
        chk("zero_nwr", 32'(wr_n), 32'd0);
        chk("zero_ntx", 32'(tx_cnt), 32'd1);
        chk("zero_reply", 32'(tx_last), 32'(ZERO_REPLY));
        chk("zero_state", 32'(state), 32'd0);

        // Ignored byte in IDLE
        send(8'h00);
        @(negedge clk);
        chk("idle_ignore", 32'(state), 32'd0);

        // Single step with TX busy for 20 cycles
        clear_logs();
        tx_busy = 1'b1;
        send(8'h53);
        repeat (20) @(negedge clk);
        chk("step_lo", 32'(stall_lo), 32'd1);
        chk("step_busy_hold", 32'(tx_cnt), 32'd0);
        chk("step_send", 32'(state), 32'd6);
        tx_busy = 1'b0;
        wait_tx("step_tx", 0, 10);
        chk("step_reply", 32'(tx_last), 32'h2E);
        chk("step_stall", 32'(stall), 32'd1);

        // Step with halt already high
        clear_logs();
        halt = 1'b1;
        send(8'h53);
        wait_tx("steph_tx", 0, 20);
        chk("steph_lo", 32'(stall_lo), 32'd0);
        chk("steph_reply", 32'(tx_last), 32'h48);
        halt = 1'b0;
        @(negedge clk);

        // Run until halt
        clear_logs();
        send(8'h52);
        repeat (49) @(negedge clk);
        chk("run_unstall", 32'(stall), 32'd0);
        halt = 1'b1;
        @(negedge clk);
        chk("run_halt_stall", 32'(stall), 32'd1);
        wait_tx("run_tx", 0, 10);
        chk("run_reply", 32'(tx_last), 32'h48);
        halt = 1'b0;
        @(negedge clk);
        clear_logs();
        send(8'h42);
        repeat (10) @(negedge clk);
        chk("idle_b_state", 32'(state), 32'd0);
        chk("idle_b_tx", 32'(tx_cnt), 32'd0);
        chk("idle_b_stall", 32'(stall_lo), 32'd0);

        // Run then break byte
        clear_logs();
        send(8'h52);
        repeat (5) @(negedge clk);
        send(8'h41);
        chk("run_other_byte", 32'(stall), 32'd0);
        send(8'h42);
        chk("brk_stall", 32'(stall), 32'd1);
        wait_tx("brk_tx", 0, 10);
        chk("brk_reply", 32'(tx_last), 32'h48);

        // Address wrap with 4-word memory
        repeat (2) @(negedge clk);
        clear_logs();
        send(8'h4C); send(8'h05); send(8'h00);
        for (int w = 0; w < 5; w++)
            for (int b = 0; b < 4; b++)
                send(8'(8'h10 + w));
        wait_tx("wrap_tx", 0, 40);
        chk("wrap_nwr", 32'(wr_n), 32'd5);
        chk("wrap_a2", 32'(wr_addr[2]), 32'd2);
        chk("wrap_a3", 32'(wr_addr[3]), 32'd3);
        chk("wrap_a4", 32'(wr_addr[4]), 32'd0);
        chk("wrap_d4", wr_data[4], 32'h14141414);
        chk("wrap_reply", 32'(tx_last), 32'(WRAP_REPLY));

        // Asynchronous reset in the middle of a load
        repeat (2) @(negedge clk);
        clear_logs();
        send(8'h4C); send(8'h01); send(8'h00);
        send(8'h77); send(8'h66);
        #2 rst = 1'b1;
        #1;
        chk("arst_stall", 32'(stall), 32'd1);
        chk("arst_cpu_rst", 32'(cpu_rst), 32'd0);
        chk("arst_we", 32'(we), 32'd0);
        chk("arst_tx_valid", 32'(tx_valid), 32'd0);
        chk("arst_state", 32'(state), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_logs();
        send(8'h4C); send(8'h01); send(8'h00);
        send(8'hBE); send(8'hBA); send(8'hFE); send(8'hCA);
        wait_tx("rld_tx", 0, 20);
        chk("rld_nwr", 32'(wr_n), 32'd1);
        chk("rld_a0", 32'(wr_addr[0]), 32'd0);
        chk("rld_d0", wr_data[0], 32'hCAFEBABE);
        chk("rld_reply", 32'(tx_last), 32'(RLD_REPLY));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
